sub_64bit_core: RTL and testbench

- Registered 64-bit two's-complement subtractor for the Y86 ALU: out = a - b.
- Flags: signed overflow, plus zero and sign flags that feed the condition codes.
- Datapath is structural, a + ~b + 1 through a ripple-carry adder; result and flags are captured in output registers.
- Sits in the AL_Unit beside the add/and/xor blocks.

---
 rtl/alu_pkg.sv | 16 +
 rtl/add_64bit.sv | 33 +++
 rtl/sub_64bit_core.sv | 65 ++++++
 tb/tb_sub_64bit_core.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the Y86 AL_Unit blocks: operand width, signed extremes
// and the condition-code flag bundle.
package alu_pkg;

  localparam int unsigned WIDTH = 64;

  localparam logic [WIDTH-1:0] INT64_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [WIDTH-1:0] INT64_MIN = 64'h8000_0000_0000_0000;

  typedef struct packed {
    logic overflow;
    logic zero;
    logic sign;
  } flags_t;

endpackage

// File: rtl/add_64bit.sv
// Ripple-carry adder with carry-in. Exposes the carries out of the top two
// slices so callers can form signed overflow as carry62 ^ carry63.
module add_64bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_c,
  output logic             carry62_c,
  output logic             carry63_c
);

  logic carry;

  // One full-adder slice per bit; carry ripples from bit 0 upward.
  always_comb begin
    sum_c     = '0;
    carry62_c = 1'b0;
    carry     = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum_c[i] = a[i] ^ b[i] ^ carry;
      carry    = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      if (i == int'(WIDTH) - 2) begin
        carry62_c = carry;
      end
    end
    carry63_c = carry;
  end

endmodule

// File: rtl/sub_64bit_core.sv
// Registered two's-complement subtractor: out = a - b computed as a + ~b + 1,
// with overflow/zero/sign captured from the same difference as out.
module sub_64bit_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             zero,
  output logic             sign
);

  logic [WIDTH-1:0] b_inv;
  logic [WIDTH-1:0] diff_c;
  logic             carry62_c;
  logic             carry63_c;
  flags_t           flags_c;
  flags_t           flags_q;

  assign b_inv = ~b;

  add_64bit #(.WIDTH(WIDTH)) u_add (
    .a         (a),
    .b         (b_inv),
    .cin       (1'b1),
    .sum_c     (diff_c),
    .carry62_c (carry62_c),
    .carry63_c (carry63_c)
  );

  // Carry into the sign slice disagreeing with carry out of it marks signed overflow.
  always_comb begin
    flags_c          = '0;
    flags_c.overflow = carry62_c ^ carry63_c;
    flags_c.zero     = (diff_c == '0);
    flags_c.sign     = diff_c[WIDTH-1];
  end

  // Result and flags update together; idle cycles hold them and clear out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      flags_q   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out     <= diff_c;
        flags_q <= flags_c;
      end
    end
  end

  assign overflow = flags_q.overflow;
  assign zero     = flags_q.zero;
  assign sign     = flags_q.sign;

endmodule

// File: tb/tb_sub_64bit_core.sv
// Self-checking bench for sub_64bit_core: directed table, random vectors,
// hold/reset sequences, with a tagged scoreboard checking one-cycle latency.
module tb_sub_64bit_core;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic [63:0] out;
  logic        overflow;
  logic        zero;
  logic        sign;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] out;
    logic        ovf;
    logic        zero;
    logic        sign;
  } vec_t;

  typedef struct {
    logic [63:0] out;
    logic        ovf;
    logic        zero;
    logic        sign;
    int          tag;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];

  sub_64bit_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out       (out),
    .overflow  (overflow),
    .zero      (zero),
    .sign      (sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: widen to 65 bits so overflow is a range check, not a carry trick.
  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input int tag);
    exp_t e;
    logic signed [64:0] wide;
    wide   = $signed({x[63], x}) - $signed({y[63], y});
    e.out  = wide[63:0];
    e.ovf  = (wide[64] != wide[63]);
    e.zero = (wide[63:0] == 64'd0);
    e.sign = wide[63];
    e.tag  = tag;
    return e;
  endfunction

  // Apply one cycle of stimulus shortly after a rising edge; push the expectation if valid.
  task automatic drive(input logic v, input logic [63:0] x, input logic [63:0] y,
                       input logic use_exp, input exp_t given);
    exp_t e;
    @(posedge clk);
    #2;
    in_valid = v;
    a        = x;
    b        = y;
    if (v) begin
      e = use_exp ? given : model(x, y, 0);
      e.tag = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    exp_t e;
    e.out = v.out; e.ovf = v.ovf; e.zero = v.zero; e.sign = v.sign; e.tag = 0;
    drive(1'b1, v.a, v.b, 1'b1, e);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("latency_cycle", 64'(cyc), 64'(e.tag));
          chk("out", out, e.out);
          chk("overflow", 64'(overflow), 64'(e.ovf));
          chk("zero", 64'(zero), 64'(e.zero));
          chk("sign", 64'(sign), 64'(e.sign));
        end
      end else if (sb.size() > 0 && sb[0].tag <= cyc) begin
        e = sb.pop_front();
        chk("missing_out_valid", 64'(out_valid), 64'd1);
      end
    end
  end

  initial begin
    exp_t dummy;
    logic [63:0] r;
    dummy = '{out: 64'd0, ovf: 1'b0, zero: 1'b0, sign: 1'b0, tag: 0};

    vecs[0] = '{a: INT64_MAX, b: INT64_MAX, out: 64'h0, ovf: 1'b0, zero: 1'b1, sign: 1'b0};
    vecs[1] = '{a: INT64_MIN, b: INT64_MIN, out: 64'h0, ovf: 1'b0, zero: 1'b1, sign: 1'b0};
    vecs[2] = '{a: INT64_MAX, b: INT64_MIN, out: 64'hFFFF_FFFF_FFFF_FFFF, ovf: 1'b1, zero: 1'b0, sign: 1'b1};
    vecs[3] = '{a: INT64_MIN, b: INT64_MAX, out: 64'h0000_0000_0000_0001, ovf: 1'b1, zero: 1'b0, sign: 1'b0};
    vecs[4] = '{a: 64'd5, b: 64'd14, out: 64'hFFFF_FFFF_FFFF_FFF7, ovf: 1'b0, zero: 1'b0, sign: 1'b1};

    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_out", out, 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_flags", 64'({overflow, zero, sign}), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed vectors back-to-back, then drop in_valid to see the hold.
    for (int i = 0; i < 5; i++) drive_vec(vecs[i]);
    drive(1'b0, 64'hDEAD_BEEF_0000_0001, 64'd3, 1'b0, dummy);
    @(negedge clk);
    @(negedge clk);
    chk("hold_out", out, 64'hFFFF_FFFF_FFFF_FFF7);
    chk("hold_out_valid", 64'(out_valid), 64'd0);
    chk("hold_sign", 64'(sign), 64'd1);

    // Random operands with occasional idle gaps and equal-operand cases.
    for (int i = 0; i < 40; i++) begin
      r = {$urandom, $urandom};
      if (i % 7 == 3) drive(1'b1, r, r, 1'b0, dummy);
      else if (i % 5 == 4) drive(1'b0, r, 64'd0, 1'b0, dummy);
      else drive(1'b1, r, {$urandom, $urandom}, 1'b0, dummy);
    end

    // Reset asserted mid-stream with in_valid high discards the pending result.
    drive_vec(vecs[2]);
    @(posedge clk);
    #3;
    in_valid = 1'b1; a = 64'd1; b = 64'd2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_out", out, 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_flags", 64'({overflow, zero, sign}), 64'd0);
    @(negedge clk);
    chk("midrst_held_valid", 64'(out_valid), 64'd0);
    #2 rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_valid", 64'(out_valid), 64'd0);
    chk("post_rst_idle_out", out, 64'd0);

    drive_vec(vecs[3]);
    drive_vec(vecs[4]);
    drive(1'b0, 64'd0, 64'd0, 1'b0, dummy);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
